decode: RTL and testbench
=========================

Name: decode

Overview:
- Instruction decode stage that sits directly downstream of the fetch stage in the multi-cycle RV32I core.
- Accepts a raw 32-bit instruction and its PC under the core's enabled/completed handshake.
- Extracts register indices, reads operands from the register file with a write-back bypass, and generates the sign-extended immediate.
- Presents registered, decoded fields to the execute stage, plus an illegal-instruction flag.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  core clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- enabled  input  1  start request from control; sampled only in IDLE
- completed  output  1  one-cycle pulse, decoded outputs valid
- instr_raw  input  32  instruction word from fetch
- pc_in  input  32  PC of instr_raw
- rf_rs1_addr  output  5  register file read port 1 index
- rf_rs2_addr  output  5  register file read port 2 index
- rf_rs1_data  input  32  combinational read data, port 1
- rf_rs2_data  input  32  combinational read data, port 2
- wb_enable  input  1  write-back stage writes this cycle
- wb_rd  input  5  write-back destination index
- wb_data  input  32  write-back value
- pc_out  output  32  latched PC
- rd  output  5  destination index (instr[11:7])
- funct3  output  3  instr[14:12]
- funct7_5  output  1  instr[30]
- instr_class  output  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 MISC_MEM, 10 SYSTEM, 15 ILLEGAL
- imm  output  32  sign-extended immediate
- rs1_val  output  32  operand 1
- rs2_val  output  32  operand 2
- illegal  output  1  instruction not RV32I-decodable

Behaviour:
- Reset (async, rstn=0): state=IDLE. All outputs are 0, except instr_class=15 (ILLEGAL). Reset mid-operation aborts the decode and does not produce a completed pulse.
- FSM states: IDLE, READ, DONE.
  - IDLE + enabled=1 (cycle N): latch instr_raw and pc_in into internal registers. Drive rf_rs1_addr=instr[19:15] and rf_rs2_addr=instr[24:20] from registers. Go to READ.
  - READ (cycle N+1): sample rf data, apply bypass, compute every decoded output, register them, and go to DONE.
  - DONE (cycle N+2): completed=1 for exactly this cycle, then go to IDLE.
  - Latency is 2 cycles from accepting enabled to completed; back-to-back throughput is 1 instruction per 3 cycles.
- completed is 0 in every cycle other than DONE.
- enabled is ignored in READ and DONE. There is no queueing.
- Decoded outputs hold their values until the next READ and remain stable after completed.
- Operand rule, applied in READ for each source:
  - index 0 → value 0;
  - else if wb_enable && wb_rd==index → wb_data;
  - else → rf data.
  - wb_rd==0 never bypasses.
- Immediate, by format:
  - I (JALR, LOAD, OP_IMM, SYSTEM): sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - OP and MISC_MEM: imm=0.
- Classification is by opcode instr[6:0]: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011.
- Illegal decode: any other opcode, or instr[1:0]!=2'b11. The result is instr_class=15, illegal=1, imm=0. The handshake still completes normally.
- funct3 and funct7 legality is not checked here; execute handles it.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), x2=0x00000005 in RF, enabled pulse at cycle 0 → completed only at cycle 2; instr_class=7, rd=1, imm=0xFFFFFFFF, rs1_val=5, illegal=0.
- sw x5,8(x6) (0x00532423), x5=0xDEADBEEF, x6=0x100 → instr_class=6, imm=8, rs1_val=0x100, rs2_val=0xDEADBEEF.
- beq x0,x0,-4 (0xFE000EE3), pc_in=0x40 → instr_class=4, imm=0xFFFFFFFC, rs1_val=rs2_val=0, pc_out=0x40.
- add x3,x1,x1 (0x001081B3) with RF x1=1, but wb_enable=1, wb_rd=1, wb_data=7 during the READ cycle → rs1_val=rs2_val=7. Repeat with wb_rd=0 and RF x0 reads 0 → both values 0.
- instr_raw=0x00000000 → illegal=1, instr_class=15, imm=0, completed pulses at cycle 2.
- enabled held high continuously → completed at cycles 2, 5, 8. Assert rstn=0 at cycle 1 → outputs reset immediately, no completed pulse; decode resumes on the next enabled.

Source files
------------

// File: rtl/decode.sv
// RV32I decode stage: latches one instruction from fetch, reads its operands
// with a write-back bypass, and registers the decoded fields for execute.
module decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  output logic            completed,
  input  logic [XLEN-1:0] instr_raw,
  input  logic [XLEN-1:0] pc_in,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_enable,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7_5,
  output logic [3:0]      instr_class,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            illegal
);

  localparam int unsigned CLS_W = 4;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [CLS_W-1:0] CLS_LUI      = CLS_W'(0);
  localparam logic [CLS_W-1:0] CLS_AUIPC    = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_JAL      = CLS_W'(2);
  localparam logic [CLS_W-1:0] CLS_JALR     = CLS_W'(3);
  localparam logic [CLS_W-1:0] CLS_BRANCH   = CLS_W'(4);
  localparam logic [CLS_W-1:0] CLS_LOAD     = CLS_W'(5);
  localparam logic [CLS_W-1:0] CLS_STORE    = CLS_W'(6);
  localparam logic [CLS_W-1:0] CLS_OP_IMM   = CLS_W'(7);
  localparam logic [CLS_W-1:0] CLS_OP       = CLS_W'(8);
  localparam logic [CLS_W-1:0] CLS_MISC_MEM = CLS_W'(9);
  localparam logic [CLS_W-1:0] CLS_SYSTEM   = CLS_W'(10);
  localparam logic [CLS_W-1:0] CLS_ILLEGAL  = CLS_W'(15);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  logic [CLS_W-1:0] cls_c;
  logic [XLEN-1:0]  imm_c;
  logic             illegal_c;
  logic [XLEN-1:0]  rs1_c;
  logic [XLEN-1:0]  rs2_c;

  // Register file is addressed straight from the latched instruction.
  assign rf_rs1_addr = instr_q[19:15];
  assign rf_rs2_addr = instr_q[24:20];

  // Opcode classification and format-specific immediate generation.
  always_comb begin
    cls_c     = CLS_ILLEGAL;
    imm_c     = '0;
    illegal_c = 1'b0;
    unique case (instr_q[6:0])
      OPC_LUI: begin
        cls_c = CLS_LUI;
        imm_c = {instr_q[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        cls_c = CLS_AUIPC;
        imm_c = {instr_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        cls_c = CLS_JAL;
        imm_c = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20],
                                instr_q[30:21], 1'b0}));
      end
      OPC_JALR: begin
        cls_c = CLS_JALR;
        imm_c = XLEN'($signed(instr_q[31:20]));
      end
      OPC_BRANCH: begin
        cls_c = CLS_BRANCH;
        imm_c = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25],
                                instr_q[11:8], 1'b0}));
      end
      OPC_LOAD: begin
        cls_c = CLS_LOAD;
        imm_c = XLEN'($signed(instr_q[31:20]));
      end
      OPC_STORE: begin
        cls_c = CLS_STORE;
        imm_c = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
      end
      OPC_OP_IMM: begin
        cls_c = CLS_OP_IMM;
        imm_c = XLEN'($signed(instr_q[31:20]));
      end
      OPC_OP:       cls_c = CLS_OP;
      OPC_MISC_MEM: cls_c = CLS_MISC_MEM;
      OPC_SYSTEM: begin
        cls_c = CLS_SYSTEM;
        imm_c = XLEN'($signed(instr_q[31:20]));
      end
      // Any other opcode, including low bits != 2'b11, lands here.
      default: illegal_c = 1'b1;
    endcase
  end

  // Source operands: x0 is hard zero, then write-back bypass, then RF.
  always_comb begin
    rs1_c = rf_rs1_data;
    rs2_c = rf_rs2_data;
    if (rf_rs1_addr == 5'd0) begin
      rs1_c = '0;
    end else if (wb_enable && (wb_rd == rf_rs1_addr)) begin
      rs1_c = wb_data;
    end
    if (rf_rs2_addr == 5'd0) begin
      rs2_c = '0;
    end else if (wb_enable && (wb_rd == rf_rs2_addr)) begin
      rs2_c = wb_data;
    end
  end

  // Handshake FSM with registered decoded outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      completed   <= 1'b0;
      pc_out      <= '0;
      rd          <= '0;
      funct3      <= '0;
      funct7_5    <= 1'b0;
      instr_class <= CLS_ILLEGAL;
      imm         <= '0;
      rs1_val     <= '0;
      rs2_val     <= '0;
      illegal     <= 1'b0;
    end else begin
      completed <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enabled) begin
            instr_q <= instr_raw;
            pc_q    <= pc_in;
            state   <= READ;
          end
        end
        READ: begin
          pc_out      <= pc_q;
          rd          <= instr_q[11:7];
          funct3      <= instr_q[14:12];
          funct7_5    <= instr_q[30];
          instr_class <= cls_c;
          imm         <= imm_c;
          rs1_val     <= rs1_c;
          rs2_val     <= rs2_c;
          illegal     <= illegal_c;
          completed   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: expectations are queued when an
// instruction is driven and compared when completed pulses.
module tb_decode;

  logic        clk;
  logic        rstn;
  logic        enabled;
  logic        completed;
  logic [31:0] instr_raw;
  logic [31:0] pc_in;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        wb_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pc_out;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [3:0]  instr_class;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        illegal;

  logic [31:0] rf [32];
  int          cyc;
  int          total;
  int          bad;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  cls;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ill;
    int          done;
  } exp_t;

  exp_t exp_q[$];

  decode dut (
    .clk        (clk),
    .rstn       (rstn),
    .enabled    (enabled),
    .completed  (completed),
    .instr_raw  (instr_raw),
    .pc_in      (pc_in),
    .rf_rs1_addr(rf_rs1_addr),
    .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data),
    .wb_enable  (wb_enable),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .pc_out     (pc_out),
    .rd         (rd),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .instr_class(instr_class),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .illegal    (illegal)
  );

  assign rf_rs1_data = rf[rf_rs1_addr];
  assign rf_rs2_data = rf[rf_rs2_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] idx, input logic we,
                                       input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wr == idx) return wd;
    return rf[idx];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic we, input logic [4:0] wr,
                                 input logic [31:0] wd, input int done);
    exp_t e;
    e.pc = pc;
    e.rd = ins[11:7];
    e.f3 = ins[14:12];
    e.f7 = ins[30];
    case (ins[6:0])
      7'h37: e.cls = 4'd0;
      7'h17: e.cls = 4'd1;
      7'h6F: e.cls = 4'd2;
      7'h67: e.cls = 4'd3;
      7'h63: e.cls = 4'd4;
      7'h03: e.cls = 4'd5;
      7'h23: e.cls = 4'd6;
      7'h13: e.cls = 4'd7;
      7'h33: e.cls = 4'd8;
      7'h0F: e.cls = 4'd9;
      7'h73: e.cls = 4'd10;
      default: e.cls = 4'd15;
    endcase
    case (e.cls)
      4'd0, 4'd1:             e.imm = {ins[31:12], 12'h000};
      4'd2:                   e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      4'd3, 4'd5, 4'd7, 4'd10: e.imm = {{20{ins[31]}}, ins[31:20]};
      4'd4:                   e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      4'd6:                   e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      default:                e.imm = 32'd0;
    endcase
    e.r1   = opnd(ins[19:15], we, wr, wd);
    e.r2   = opnd(ins[24:20], we, wr, wd);
    e.ill  = (e.cls == 4'd15);
    e.done = done;
    return e;
  endfunction

  // Compare decoded outputs whenever completed is seen.
  always @(negedge clk) begin
    if (completed) begin
      if (exp_q.size() == 0) begin
        check("spurious_completed", 32'(completed), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency",  32'(cyc),      32'(e.done));
        check("pc_out",   pc_out,        e.pc);
        check("rd",       32'(rd),       32'(e.rd));
        check("funct3",   32'(funct3),   32'(e.f3));
        check("funct7_5", 32'(funct7_5), 32'(e.f7));
        check("class",    32'(instr_class), 32'(e.cls));
        check("imm",      imm,           e.imm);
        check("rs1_val",  rs1_val,       e.r1);
        check("rs2_val",  rs2_val,       e.r2);
        check("illegal",  32'(illegal),  32'(e.ill));
      end
    end
  end

  // One decode: enabled for a single cycle, write-back values during READ.
  task automatic run_one(input logic [31:0] ins, input logic [31:0] pc,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    instr_raw = ins;
    pc_in     = pc;
    enabled   = 1'b1;
    exp_q.push_back(model(ins, pc, we, wr, wd, cyc + 2));
    @(negedge clk);
    enabled   = 1'b0;
    instr_raw = 32'h0;
    wb_enable = we;
    wb_rd     = wr;
    wb_data   = wd;
    @(negedge clk);
    wb_enable = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] r;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rstn      = 1'b0;
    enabled   = 1'b0;
    instr_raw = 32'h0;
    pc_in     = 32'h0;
    wb_enable = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = 32'h0;
    rf[1] = 32'h1;
    rf[2] = 32'h5;
    rf[5] = 32'hDEADBEEF;
    rf[6] = 32'h100;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};

    #12;
    check("rst_completed", 32'(completed), 32'd0);
    check("rst_class",     32'(instr_class), 32'd15);
    check("rst_imm",       imm, 32'd0);
    check("rst_illegal",   32'(illegal), 32'd0);
    check("rst_pc_out",    pc_out, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // addi x1,x2,-1
    run_one(32'hFFF10093, 32'h0, 1'b0, 5'd0, 32'h0);
    check("addi_class", 32'(instr_class), 32'd7);
    check("addi_rd",    32'(rd), 32'd1);
    check("addi_imm",   imm, 32'hFFFFFFFF);
    check("addi_rs1",   rs1_val, 32'd5);
    check("addi_ill",   32'(illegal), 32'd0);
    check("hold_completed", 32'(completed), 32'd0);

    // sw x5,8(x6)
    run_one(32'h00532423, 32'h4, 1'b0, 5'd0, 32'h0);
    check("sw_class", 32'(instr_class), 32'd6);
    check("sw_imm",   imm, 32'd8);
    check("sw_rs1",   rs1_val, 32'h100);
    check("sw_rs2",   rs2_val, 32'hDEADBEEF);

    // beq x0,x0,-4
    run_one(32'hFE000EE3, 32'h40, 1'b0, 5'd0, 32'h0);
    check("beq_class", 32'(instr_class), 32'd4);
    check("beq_imm",   imm, 32'hFFFFFFFC);
    check("beq_rs1",   rs1_val, 32'd0);
    check("beq_rs2",   rs2_val, 32'd0);
    check("beq_pc",    pc_out, 32'h40);

    // add x3,x1,x1 with bypass of x1
    run_one(32'h001081B3, 32'h44, 1'b1, 5'd1, 32'd7);
    check("byp_rs1", rs1_val, 32'd7);
    check("byp_rs2", rs2_val, 32'd7);

    // add x3,x0,x0 with write-back to x0: no bypass
    run_one(32'h000001B3, 32'h48, 1'b1, 5'd0, 32'd7);
    check("x0_rs1", rs1_val, 32'd0);
    check("x0_rs2", rs2_val, 32'd0);

    // all-zero word is illegal
    run_one(32'h00000000, 32'h4C, 1'b0, 5'd0, 32'h0);
    check("ill_flag",  32'(illegal), 32'd1);
    check("ill_class", 32'(instr_class), 32'd15);
    check("ill_imm",   imm, 32'd0);

    // enabled held high: completions every third cycle
    @(negedge clk);
    instr_raw = 32'hFFF10093;
    pc_in     = 32'h80;
    enabled   = 1'b1;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(model(32'hFFF10093, 32'h80, 1'b0, 5'd0, 32'h0, cyc + 2 + 3 * k));
    repeat (7) @(negedge clk);
    enabled = 1'b0;
    repeat (3) @(negedge clk);

    // reset during READ aborts the decode
    instr_raw = 32'h00532423;
    pc_in     = 32'h90;
    enabled   = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    rstn    = 1'b0;
    #1;
    check("abort_completed", 32'(completed), 32'd0);
    check("abort_class",     32'(instr_class), 32'd15);
    check("abort_imm",       imm, 32'd0);
    check("abort_rs1",       rs1_val, 32'd0);
    check("abort_pc",        pc_out, 32'd0);
    check("abort_rfaddr",    32'(rf_rs1_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    run_one(32'h00532423, 32'h94, 1'b0, 5'd0, 32'h0);
    check("resume_imm", imm, 32'd8);

    // randomized instructions, including garbage in RF x0
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom();
      r = $urandom();
      ops[11] = r[6:0];
      r = $urandom();
      run_one({r[31:7], ops[$urandom_range(0, 11)]}, $urandom(), 1'($urandom()),
              5'($urandom()), $urandom());
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
